// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter_if
//  Description : SRAM-like bus between the arbiter (master) and the
//                SRAM-like-to-AXI bridge (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_bus_arbiter_if;
    logic        m_req;
    logic        m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_wr, m_size, m_addr, m_wdata,
        input  m_addr_ok, m_data_ok, m_rdata
    );

    modport slave (
        input  m_req, m_wr, m_size, m_addr, m_wdata,
        output m_addr_ok, m_data_ok, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Shares one SRAM-like bus between the fetch port and the MEM
//                port, one transaction in flight. Buffers the finished result
//                until the stalled pipeline advances and produces the
//                fetch/data stall signals for the hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    // fetch port
    input  wire logic        i_req,
    input  wire logic [31:0] i_addr,
    output logic      [31:0] i_rdata,
    output logic             i_stall,
    // MEM port
    input  wire logic        d_req,
    input  wire logic        d_wr,
    input  wire logic [1:0]  d_size,
    input  wire logic [31:0] d_addr,
    input  wire logic [31:0] d_wdata,
    output logic      [31:0] d_rdata,
    output logic             d_stall,
    // pipeline control
    input  wire logic        longest_stall,
    input  wire logic        flush,
    // bus towards the bridge
    sram_bus_arbiter_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_stateNext;

    logic        r_mWr;
    logic [1:0]  r_mSize;
    logic [31:0] r_mAddr;
    logic [31:0] r_mWdata;
    logic [31:0] r_iRdata;
    logic [31:0] r_dRdata;
    logic        r_iDone;
    logic        r_dDone;
    logic        r_iDrop;

    logic        w_iPend;
    logic        w_dPend;
    logic        w_grantI;
    logic        w_grantD;
    logic        w_iFinish;
    logic        w_dFinish;
    logic        w_iDiscard;
    logic        w_inFetch;

    // Pending work is only what has not been satisfied yet; a flushed fetch
    // is not started at all.
    assign w_dPend = d_req & ~r_dDone;
    assign w_iPend = i_req & ~r_iDone & ~flush;

    // A transfer finishes on data_ok in the data phase, or in the address
    // phase when addr_ok and data_ok coincide.
    assign w_iFinish = ((r_state == I_ADDR) & bus.m_addr_ok & bus.m_data_ok) |
                       ((r_state == I_DATA) & bus.m_data_ok);
    assign w_dFinish = ((r_state == D_ADDR) & bus.m_addr_ok & bus.m_data_ok) |
                       ((r_state == D_DATA) & bus.m_data_ok);

    assign w_inFetch  = (r_state == I_ADDR) | (r_state == I_DATA);
    // A fetch flushed at any point of its flight is thrown away on arrival.
    assign w_iDiscard = r_iDrop | flush;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic and IDLE arbitration.
    always_comb begin
        w_stateNext = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_dPend && (DATA_FIRST || !w_iPend)) begin
                    w_grantD    = 1'b1;
                    w_stateNext = D_ADDR;
                end else if (w_iPend) begin
                    w_grantI    = 1'b1;
                    w_stateNext = I_ADDR;
                end
            end
            I_ADDR: begin
                if (bus.m_addr_ok) begin
                    w_stateNext = bus.m_data_ok ? IDLE : I_DATA;
                end
            end
            I_DATA: begin
                if (bus.m_data_ok) begin
                    w_stateNext = IDLE;
                end
            end
            D_ADDR: begin
                if (bus.m_addr_ok) begin
                    w_stateNext = bus.m_data_ok ? IDLE : D_DATA;
                end
            end
            D_DATA: begin
                if (bus.m_data_ok) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Latch the winner's request fields; they stay stable until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mWr    <= 1'b0;
            r_mSize  <= 2'd0;
            r_mAddr  <= 32'd0;
            r_mWdata <= 32'd0;
        end else if (w_grantD) begin
            r_mWr    <= d_wr;
            r_mSize  <= d_size;
            r_mAddr  <= d_addr;
            r_mWdata <= d_wdata;
        end else if (w_grantI) begin
            r_mWr    <= 1'b0;
            r_mSize  <= 2'd2;
            r_mAddr  <= i_addr;
            r_mWdata <= 32'd0;
        end
    end

    // Fetch result buffer, done flag and flush-drop marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iRdata <= 32'd0;
            r_iDone  <= 1'b0;
            r_iDrop  <= 1'b0;
        end else begin
            if (w_iFinish && !w_iDiscard) begin
                r_iRdata <= bus.m_rdata;
                r_iDone  <= 1'b1;
            end else if (!longest_stall) begin
                r_iDone  <= 1'b0;
            end

            if (w_iFinish) begin
                r_iDrop <= 1'b0;
            end else if (flush && w_inFetch) begin
                r_iDrop <= 1'b1;
            end
        end
    end

    // Data result buffer and done flag; stores leave the load buffer alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dRdata <= 32'd0;
            r_dDone  <= 1'b0;
        end else if (w_dFinish) begin
            r_dDone <= 1'b1;
            if (!r_mWr) begin
                r_dRdata <= bus.m_rdata;
            end
        end else if (!longest_stall) begin
            r_dDone <= 1'b0;
        end
    end

    assign bus.m_req   = (r_state == I_ADDR) | (r_state == D_ADDR);
    assign bus.m_wr    = r_mWr;
    assign bus.m_size  = r_mSize;
    assign bus.m_addr  = r_mAddr;
    assign bus.m_wdata = r_mWdata;

    assign i_rdata = r_iRdata;
    assign d_rdata = r_dRdata;
    assign i_stall = i_req & ~r_iDone;
    assign d_stall = d_req & ~r_dDone;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_arbiter
//  Description : Directed self-checking bench for sram_bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        flush;

    int nChecks;
    int nErrors;

    sram_bus_arbiter_if bus ();

    sram_bus_arbiter #(
        .DATA_FIRST (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_rdata       (i_rdata),
        .i_stall       (i_stall),
        .d_req         (d_req),
        .d_wr          (d_wr),
        .d_size        (d_size),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_rdata       (d_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .flush         (flush),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst = 1'b1;
        i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_wr = 1'b0; d_size = 2'd0; d_addr = 32'd0; d_wdata = 32'd0;
        longest_stall = 1'b0; flush = 1'b0;
        bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = 32'd0;

        step(); step();
        chk("rst_mreq",   bus.m_req,   32'd0);
        chk("rst_maddr",  bus.m_addr,  32'd0);
        chk("rst_msize",  bus.m_size,  32'd0);
        chk("rst_irdata", i_rdata,     32'd0);
        chk("rst_drdata", d_rdata,     32'd0);
        rst = 1'b0;
        step();

        // T1: fetch only, addr_ok in c2, data_ok in c3
        i_req = 1'b1; i_addr = 32'hBFC0_0000; longest_stall = 1'b1;
        #1 chk("t1_c1_istall", i_stall, 32'd1);
        step();
        chk("t1_c2_mreq",  bus.m_req,  32'd1);
        chk("t1_c2_maddr", bus.m_addr, 32'hBFC0_0000);
        chk("t1_c2_msize", bus.m_size, 32'd2);
        chk("t1_c2_mwr",   bus.m_wr,   32'd0);
        bus.m_addr_ok = 1'b1;
        step();
        bus.m_addr_ok = 1'b0;
        chk("t1_c3_mreq",   bus.m_req, 32'd0);
        chk("t1_c3_istall", i_stall,   32'd1);
        bus.m_data_ok = 1'b1; bus.m_rdata = 32'h2408_0001;
        step();
        bus.m_data_ok = 1'b0; bus.m_rdata = 32'd0;
        chk("t1_c4_irdata", i_rdata, 32'h2408_0001);
        chk("t1_c4_istall", i_stall, 32'd0);
        i_req = 1'b0; longest_stall = 1'b0;
        step();

        // T2: simultaneous load and fetch, data wins
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2; d_addr = 32'h8000_0010;
        i_req = 1'b1; i_addr = 32'hBFC0_0004; longest_stall = 1'b1;
        step();
        chk("t2_first_maddr", bus.m_addr, 32'h8000_0010);
        chk("t2_first_mreq",  bus.m_req,  32'd1);
        bus.m_addr_ok = 1'b1;
        step();
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b1; bus.m_rdata = 32'h1111_2222;
        step();
        bus.m_data_ok = 1'b0;
        chk("t2_dstall_drop", d_stall, 32'd0);
        chk("t2_istall_held", i_stall, 32'd1);
        chk("t2_drdata",      d_rdata, 32'h1111_2222);
        step();
        chk("t2_second_maddr", bus.m_addr, 32'hBFC0_0004);
        chk("t2_second_mreq",  bus.m_req,  32'd1);
        chk("t2_dstall_still", d_stall,    32'd0);
        bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'h3333_4444;
        step();
        bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0;
        chk("t2_istall_drop", i_stall, 32'd0);
        chk("t2_irdata",      i_rdata, 32'h3333_4444);
        chk("t2_no_reissue",  bus.m_req, 32'd0);
        d_req = 1'b0; i_req = 1'b0; longest_stall = 1'b0;
        step();

        // T3: store word, addr_ok delayed 4 cycles
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h8000_0020;
        d_wdata = 32'hDEAD_BEEF; longest_stall = 1'b1;
        step();
        d_wdata = 32'h0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            chk("t3_mreq",   bus.m_req,   32'd1);
            chk("t3_mwr",    bus.m_wr,    32'd1);
            chk("t3_msize",  bus.m_size,  32'd2);
            chk("t3_maddr",  bus.m_addr,  32'h8000_0020);
            chk("t3_mwdata", bus.m_wdata, 32'hDEAD_BEEF);
            if (k < 3) step();
        end
        bus.m_addr_ok = 1'b1;
        step();
        bus.m_addr_ok = 1'b0;
        chk("t3_data_mreq", bus.m_req, 32'd0);
        chk("t3_dstall",    d_stall,   32'd1);
        bus.m_data_ok = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
        step();
        bus.m_data_ok = 1'b0;
        chk("t3_done_dstall", d_stall, 32'd0);
        chk("t3_drdata_kept", d_rdata, 32'h1111_2222);
        d_req = 1'b0; d_wr = 1'b0; longest_stall = 1'b0;
        step();

        // T4: load completes while the pipeline stays held for 3 cycles
        d_req = 1'b1; d_addr = 32'h8000_0030; longest_stall = 1'b1;
        step();
        bus.m_addr_ok = 1'b1;
        step();
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b1; bus.m_rdata = 32'h5566_7788;
        step();
        bus.m_data_ok = 1'b0; bus.m_rdata = 32'd0;
        for (int k = 0; k < 3; k++) begin
            chk("t4_hold_dstall", d_stall,   32'd0);
            chk("t4_hold_mreq",   bus.m_req, 32'd0);
            chk("t4_hold_drdata", d_rdata,   32'h5566_7788);
            step();
        end
        longest_stall = 1'b0;
        step();
        chk("t4_cleared_dstall", d_stall, 32'd1);
        d_req = 1'b0;
        step();
        chk("t4_idle_mreq", bus.m_req, 32'd0);

        // T5: flush during the fetch data phase
        i_req = 1'b1; i_addr = 32'hBFC0_0100; longest_stall = 1'b1;
        step();
        chk("t5_maddr", bus.m_addr, 32'hBFC0_0100);
        bus.m_addr_ok = 1'b1;
        step();
        bus.m_addr_ok = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.m_data_ok = 1'b1; bus.m_rdata = 32'h9999_9999;
        step();
        bus.m_data_ok = 1'b0;
        chk("t5_irdata_kept", i_rdata, 32'h3333_4444);
        chk("t5_istall_held", i_stall, 32'd1);
        i_addr = 32'hBFC0_0380;
        step();
        chk("t5_new_maddr", bus.m_addr, 32'hBFC0_0380);
        chk("t5_new_mreq",  bus.m_req,  32'd1);
        bus.m_addr_ok = 1'b1; bus.m_data_ok = 1'b1; bus.m_rdata = 32'hAAAA_5555;
        step();
        bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0;
        chk("t5_new_irdata", i_rdata, 32'hAAAA_5555);
        chk("t5_new_istall", i_stall, 32'd0);
        i_req = 1'b0; longest_stall = 1'b0;
        step();

        // T6: reset while in the data address phase
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd1; d_addr = 32'h8000_0040;
        d_wdata = 32'h1234_5678;
        step();
        chk("t6_pre_mreq",  bus.m_req,  32'd1);
        chk("t6_pre_maddr", bus.m_addr, 32'h8000_0040);
        rst = 1'b1; d_req = 1'b0;
        step();
        chk("t6_mreq",   bus.m_req,   32'd0);
        chk("t6_mwr",    bus.m_wr,    32'd0);
        chk("t6_msize",  bus.m_size,  32'd0);
        chk("t6_maddr",  bus.m_addr,  32'd0);
        chk("t6_mwdata", bus.m_wdata, 32'd0);
        chk("t6_irdata", i_rdata,     32'd0);
        chk("t6_drdata", d_rdata,     32'd0);
        chk("t6_dstall", d_stall,     32'd0);
        rst = 1'b0;
        step();
        chk("t6_idle_mreq", bus.m_req, 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
